i2c_config_transmitter: RTL and testbench
=========================================

# i2c_config_transmitter

Serial master that sits directly downstream of the slow clock generator in the audio/video configuration path. It consumes that generator's divided clock level and its one-cycle phase strobes (rising, falling, mid-high, mid-low), and uses them to place a write-only I2C transfer on the bus. Each transfer is a START condition, NUM_BYTES bytes sent MSB first with an ACK slot after each byte, then a STOP condition. It is used to program codec and video-decoder registers.

## Interface
- NUM_BYTES, 3, number of bytes per transfer; legal values 1..4.
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high; clock clk.
- scl_level  in  1  divided clock level from the slow clock generator.
- scl_rise  in  1  one-cycle strobe: scl_level has just gone high.
- scl_fall  in  1  one-cycle strobe: scl_level has just gone low.
- scl_mid_high  in  1  one-cycle strobe: middle of the high phase.
- scl_mid_low  in  1  one-cycle strobe: middle of the low phase.
- start  in  1  transfer request; sampled only while busy=0.
- data_in  in  8*NUM_BYTES  payload; the most significant byte is sent first.
- sda_in  in  1  sampled bus SDA.
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA (open-drain).
- i2c_sclk  out  1  bus SCL.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer ends (normally or aborted).
- ack_err  out  1  sticky NACK flag; cleared on the next accepted start.

## Operation
- i2c_sclk = scl_gate ? scl_level : 1.
- States:
  - IDLE → START_C on start with busy=0.
    - On acceptance: latch data_in into the shift register, clear ack_err, set busy, set byte_cnt=0 and bit_cnt=0.
  - START_C: on scl_mid_high, assert sda_oe (SDA falls while SCL is high). Go to GATE.
  - GATE: on scl_fall, set scl_gate=1. Go to BITS.
  - BITS: on scl_mid_low, sda_oe = ~shift[MSB], shift left by one, bit_cnt++. After the 8th bit, go to ACK.
  - ACK:
    - On scl_mid_low, release SDA (sda_oe=0).
    - On the next scl_mid_high, sample sda_in.
    - If sda_in=1: set ack_err and go to STOP_L (abort).
    - Otherwise: byte_cnt++, then go to STOP_L if byte_cnt reaches NUM_BYTES, else go to BITS.
  - STOP_L: on scl_mid_low, assert sda_oe. Go to STOP_R.
  - STOP_R: on scl_rise, clear scl_gate so SCL stays high. Go to STOP_H.
  - STOP_H: on scl_mid_high, release SDA (SDA rises while SCL is high). Pulse done, clear busy, go to IDLE.
- Each state reacts only to its named strobe; all other strobes are ignored in that state.
- start while busy=1 is ignored; data_in is not re-latched.

## Timing
- Reset values:
  - sda_oe=0, i2c_sclk=1, busy=0, done=0, ack_err=0.
  - scl_gate=0, state=IDLE, counters 0, shift register 0.
- busy rises one clk after start is sampled.
- An action triggered by a strobe is visible on the outputs one clk after that strobe.
- A strobe arriving in the same cycle as the accepted start is not consumed; the FSM responds to strobes from the following cycle.
- done is high for exactly one clk, in the same cycle busy falls; start is accepted again in the next cycle.
- Reset mid-transfer releases SDA and forces SCL high on the next edge. No STOP is generated.
- Bus period = slow-clock period. A complete NUM_BYTES=3 transfer takes 29 slow-clock periods (START, 27 data/ACK bits, STOP), ±1.

## Configuration
- I2C_ACK_CHECK_EN defined:
  - ACK-slot sda_in is sampled.
  - NACK sets ack_err and aborts to STOP_L.
- Not defined:
  - ACK slot still released for one SCL period, but sda_in is ignored.
  - ack_err tied to 0.
  - All NUM_BYTES bytes are always sent.

## Structure
- Package i2c_pkg:
  - state enum typedef;
  - ACK=1'b0 and NACK=1'b1 constants;
  - BITS_PER_BYTE=8.
- Sub-module i2c_tx_shifter: load, shift-on-strobe and bit counter, returning the current bit and a byte-done flag. The FSM, SCL gating and ACK logic stay in the top level.

## Test plan
- Reset held for 3 clk mid-transfer → sda_oe=0 and i2c_sclk=1 the cycle after reset; busy=0; ack_err=0.
- NUM_BYTES=3, data_in=24'h34_1E_A5, sda_in held 0 → bus decode yields START, 0x34 ACK, 0x1E ACK, 0xA5 ACK, STOP; done pulses once; ack_err=0.
- sda_in=1 during the first ACK slot, macro defined → START, 0x34, NACK, then STOP; no further bytes; ack_err=1 until the next start.
- Same stimulus, macro undefined → all three bytes sent; ack_err=0.
- start re-pulsed while busy, with data_in changed to 24'hFFFFFF → ignored; the original payload completes unchanged.
- start asserted in the same cycle as scl_mid_high → SDA falls on the following mid-high, not this one; SDA never changes while i2c_sclk is high except at START and STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C configuration transmitter.
package i2c_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned BIT_CNT_W     = 3;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_C,
        S_GATE,
        S_BITS,
        S_ACK,
        S_STOP_L,
        S_STOP_R,
        S_STOP_H
    } state_e;

endpackage

// File: rtl/i2c_tx_shifter.sv
// Payload shift register with per-byte bit counter; presents the current MSB
// and flags when the bit being shifted out is the last one of its byte.
module i2c_tx_shifter
    import i2c_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             bit_c,
    output logic             last_bit_c
);

    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    // Load wins over shift; the counter wraps naturally at a byte boundary.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            shift_d   = data_in;
            bit_cnt_d = '0;
        end else if (shift) begin
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_c      = shift_q[WIDTH-1];
    assign last_bit_c = (bit_cnt_q == BIT_CNT_W'(BITS_PER_BYTE - 1));

endmodule

// File: rtl/i2c_config_transmitter.sv
// Write-only I2C master driven by slow-clock phase strobes: START, NUM_BYTES
// bytes MSB first with ACK slots, STOP. Define I2C_ACK_CHECK_EN to abort on NACK.
module i2c_config_transmitter
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_BYTES = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               scl_level,
    input  logic                               scl_rise,
    input  logic                               scl_fall,
    input  logic                               scl_mid_high,
    input  logic                               scl_mid_low,
    input  logic                               start,
    input  logic [BITS_PER_BYTE*NUM_BYTES-1:0] data_in,
    input  logic                               sda_in,
    output logic                               sda_oe,
    output logic                               i2c_sclk,
    output logic                               busy,
    output logic                               done,
    output logic                               ack_err
);

    localparam int unsigned DATA_W     = BITS_PER_BYTE * NUM_BYTES;
    localparam int unsigned BYTE_CNT_W = 3;

`ifdef I2C_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    state_e                state_q, state_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  scl_gate_q, scl_gate_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ack_err_q, ack_err_d;
    logic                  ack_rel_q, ack_rel_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;

    logic load_c, shift_c, bit_c, last_bit_c, nack_c;

    i2c_tx_shifter #(.WIDTH(DATA_W)) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (load_c),
        .shift      (shift_c),
        .data_in    (data_in),
        .bit_c      (bit_c),
        .last_bit_c (last_bit_c)
    );

    // Without ACK checking the slave's answer never aborts the transfer.
    assign nack_c = ACK_CHECK && (sda_in == NACK);

    always_comb begin
        state_d    = state_q;
        sda_oe_d   = sda_oe_q;
        scl_gate_d = scl_gate_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
        ack_rel_d  = ack_rel_q;
        byte_cnt_d = byte_cnt_q;
        load_c     = 1'b0;
        shift_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_c     = 1'b1;
                    ack_err_d  = 1'b0;
                    busy_d     = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = S_START_C;
                end
            end
            S_START_C: begin
                if (scl_mid_high) begin
                    sda_oe_d = 1'b1;
                    state_d  = S_GATE;
                end
            end
            S_GATE: begin
                if (scl_fall) begin
                    scl_gate_d = 1'b1;
                    state_d    = S_BITS;
                end
            end
            S_BITS: begin
                if (scl_mid_low) begin
                    sda_oe_d = ~bit_c;
                    shift_c  = 1'b1;
                    if (last_bit_c) begin
                        ack_rel_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end
            end
            // First half releases SDA in the low phase, second half samples in the high phase.
            S_ACK: begin
                if (!ack_rel_q) begin
                    if (scl_mid_low) begin
                        sda_oe_d  = 1'b0;
                        ack_rel_d = 1'b1;
                    end
                end else if (scl_mid_high) begin
                    ack_rel_d = 1'b0;
                    if (nack_c) begin
                        ack_err_d = 1'b1;
                        state_d   = S_STOP_L;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        if (byte_cnt_q == BYTE_CNT_W'(NUM_BYTES - 1)) begin
                            state_d = S_STOP_L;
                        end else begin
                            state_d = S_BITS;
                        end
                    end
                end
            end
            S_STOP_L: begin
                if (scl_mid_low) begin
                    sda_oe_d = 1'b1;
                    state_d  = S_STOP_R;
                end
            end
            S_STOP_R: begin
                if (scl_rise) begin
                    scl_gate_d = 1'b0;
                    state_d    = S_STOP_H;
                end
            end
            S_STOP_H: begin
                if (scl_mid_high) begin
                    sda_oe_d = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sda_oe_q   <= 1'b0;
            scl_gate_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            ack_rel_q  <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sda_oe_q   <= sda_oe_d;
            scl_gate_q <= scl_gate_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            ack_rel_q  <= ack_rel_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign i2c_sclk = scl_gate_q ? scl_level : 1'b1;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_i2c_config_transmitter.sv
// Directed bench: phase-strobe generator, bus decoder on SCL/SDA, checks of
// START/bytes/ACK slots/STOP, NACK abort, ignored re-start and reset recovery.
module tb_i2c_config_transmitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] data_in;
    logic        sda_in;
    logic        sda_oe, i2c_sclk, busy, done, ack_err;
    logic        scl_level, scl_rise, scl_fall, scl_mid_high, scl_mid_low;
    logic [3:0]  ph = 4'd0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 16-clk slow clock: high for phases 0..7, low for 8..15.
    always @(posedge clk) ph <= ph + 4'd1;
    assign scl_level    = (ph < 4'd8);
    assign scl_rise     = (ph == 4'd0);
    assign scl_mid_high = (ph == 4'd4);
    assign scl_fall     = (ph == 4'd8);
    assign scl_mid_low  = (ph == 4'd12);

    i2c_config_transmitter #(.NUM_BYTES(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .scl_level    (scl_level),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .scl_mid_high (scl_mid_high),
        .scl_mid_low  (scl_mid_low),
        .start        (start),
        .data_in      (data_in),
        .sda_in       (sda_in),
        .sda_oe       (sda_oe),
        .i2c_sclk     (i2c_sclk),
        .busy         (busy),
        .done         (done),
        .ack_err      (ack_err)
    );

    // Bus decoder, master-driven SDA only (ACK slots read back as released = 1).
    logic       mon_clr;
    logic       sda_line;
    logic       scl_p, sda_p;
    logic [7:0] sr;
    logic [7:0] bytes [0:3];
    logic [3:0] ackbits;
    int start_cnt, stop_cnt, done_cnt, bad_done, nbytes, bitn;

    assign sda_line = ~sda_oe;

    always @(negedge clk) begin
        if (mon_clr) begin
            start_cnt <= 0;
            stop_cnt  <= 0;
            done_cnt  <= 0;
            bad_done  <= 0;
            nbytes    <= 0;
            bitn      <= 0;
            sr        <= 8'h00;
            ackbits   <= 4'h0;
            scl_p     <= 1'b1;
            sda_p     <= 1'b1;
            for (int i = 0; i < 4; i++) bytes[i] <= 8'h00;
        end else begin
            scl_p <= i2c_sclk;
            sda_p <= sda_line;
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (busy) bad_done <= bad_done + 1;
            end
            if (i2c_sclk && scl_p && sda_p && !sda_line) begin
                start_cnt <= start_cnt + 1;
                bitn      <= 0;
            end else if (i2c_sclk && scl_p && !sda_p && sda_line) begin
                stop_cnt <= stop_cnt + 1;
                bitn     <= 0;
            end else if (i2c_sclk && !scl_p) begin
                sr <= {sr[6:0], sda_line};
                if (bitn == 8) begin
                    if (nbytes < 4) begin
                        bytes[nbytes[1:0]]   <= sr;
                        ackbits[nbytes[1:0]] <= sda_line;
                    end
                    nbytes <= nbytes + 1;
                    bitn   <= 0;
                end else begin
                    bitn <= bitn + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clears the decoder, optionally aligns start with a mid-high strobe, then pulses start.
    task automatic launch(input string tag, input logic [23:0] d, input bit align);
        step();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
        if (align) begin
            for (int i = 0; i < 16 && ph != 4'd4; i++) step();
        end
        data_in = d;
        start   = 1'b1;
        step();
        start   = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        chk({tag, "_ack_err_clr"}, 32'(ack_err), 32'd0);
    endtask

    task automatic wait_done(input string tag, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_bus(input string tag, input logic [23:0] exp, input int nexp);
        logic [23:0] e;
        logic [3:0]  mask;
        e    = exp;
        mask = 4'((1 << nexp) - 1);
        step();
        step();
        chk({tag, "_starts"}, 32'(start_cnt), 32'd1);
        chk({tag, "_stops"}, 32'(stop_cnt), 32'd1);
        chk({tag, "_nbytes"}, 32'(nbytes), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(bytes[i]), 32'(e[23-8*i -: 8]));
        end
        chk({tag, "_ack_slots_released"}, 32'(ackbits & mask), 32'(mask));
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_with_busy"}, 32'(bad_done), 32'd0);
    endtask

    initial begin
        int n;
        bit hit;
        reset   = 1'b1;
        start   = 1'b0;
        data_in = 24'h0;
        sda_in  = 1'b0;
        mon_clr = 1'b1;
        repeat (3) step();
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_sclk", 32'(i2c_sclk), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        reset = 1'b0;

        // Start coincides with mid-high: SDA must fall on the next mid-high, 16 clks later.
        launch("align", 24'h341EA5, 1'b1);
        chk("align_sda_not_yet", 32'(sda_oe), 32'd0);
        repeat (15) step();
        chk("align_sda_before_start", 32'(sda_oe), 32'd0);
        step();
        chk("align_sda_start", 32'(sda_oe), 32'd1);
        chk("align_sclk_high_at_start", 32'(i2c_sclk), 32'd1);
        wait_done("align", n);
        chk("align_duration", 32'(n), 32'd449);
        chk("align_ack_err", 32'(ack_err), 32'd0);
        check_bus("align", 24'h341EA5, 3);

        // Restart while busy with a different payload is ignored.
        launch("repulse", 24'h341EA5, 1'b0);
        repeat (100) step();
        data_in = 24'hFFFFFF;
        start   = 1'b1;
        step();
        start   = 1'b0;
        wait_done("repulse", n);
        check_bus("repulse", 24'h341EA5, 3);

        // Slave NACKs (SDA high for the whole transfer).
        sda_in = 1'b1;
        launch("nack", 24'h341EA5, 1'b0);
        wait_done("nack", n);
`ifdef I2C_ACK_CHECK_EN
        chk("nack_ack_err", 32'(ack_err), 32'd1);
        check_bus("nack", 24'h341EA5, 1);
        repeat (20) step();
        chk("nack_ack_err_sticky", 32'(ack_err), 32'd1);
`else
        chk("nack_ack_err", 32'(ack_err), 32'd0);
        check_bus("nack", 24'h341EA5, 3);
`endif

        // Reset held 3 clks in the middle of a transfer.
        launch("midrst", 24'h341EA5, 1'b0);
`ifdef I2C_ACK_CHECK_EN
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            step();
            if (ack_err) hit = 1'b1;
        end
        chk("midrst_nack_seen", 32'(hit), 32'd1);
`else
        repeat (100) step();
`endif
        chk("midrst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_sda_oe", 32'(sda_oe), 32'd0);
        chk("midrst_sclk", 32'(i2c_sclk), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ack_err", 32'(ack_err), 32'd0);
        repeat (40) step();
        chk("midrst_stays_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
